nios_upc_pio_edge: RTL and testbench



---
 rtl/nios_upc_pio_pkg.sv | 23 ++
 rtl/nios_upc_pio_sync.sv | 44 ++++
 rtl/nios_upc_pio_edge.sv | 109 ++++++++++
 tb/tb_nios_upc_pio_edge.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/nios_upc_pio_pkg.sv
// Shared constants for the edge-capturing GPIO PIO: register map and type selectors.
// Latency: n/a (constants only).
// Backpressure: n/a.
package nios_upc_pio_pkg;

    // Word register indices on the Avalon-MM slave
    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_DIR    = 3'd1;
    localparam logic [2:0] ADDR_MASK   = 3'd2;
    localparam logic [2:0] ADDR_EDGE   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;

    // EDGE_TYPE selectors
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // IRQ_TYPE selectors
    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/nios_upc_pio_sync.sv
// Pin input synchroniser with a trailing previous-sample flop and edge detector.
// Latency: sync valid SYNC_STAGES clocks after a pin change; edge_det asserts combinationally with it.
// Backpressure: none; free-running every clock.
//
// Ports: clk, reset (async active-high), in_port (async pins),
//        sync (synchronised pins), edge_det (per-bit edge per EDGE_TYPE).
import nios_upc_pio_pkg::*;

module nios_upc_pio_sync #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] edge_det
);

    logic [WIDTH-1:0] stage [SYNC_STAGES];
    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
            prev <= '0;
        end else begin
            stage[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
            prev <= stage[SYNC_STAGES-1];
        end
    end

    assign sync = stage[SYNC_STAGES-1];

    always_comb begin
        edge_det = '0;
        if (EDGE_TYPE == EDGE_FALL)     edge_det = ~sync & prev;
        else if (EDGE_TYPE == EDGE_ANY) edge_det = sync ^ prev;
        else                            edge_det = sync & ~prev;
    end

endmodule

// File: rtl/nios_upc_pio_edge.sv
// WIDTH-bit bidirectional Avalon-MM PIO with direction, edge capture, IRQ mask and atomic set/clear.
// Latency: zero-wait-state reads; writes take effect on the next clk; pin to edgecapture SYNC_STAGES+1 clocks.
// Backpressure: none; slave never stalls, every access completes in one cycle.
//
// Ports: clk, reset (async active-high), address/chipselect/write_n/writedata/readdata (Avalon-MM),
//        in_port (pins), out_port (data register), out_en (direction, 1 = drive), irq (active-high).
// Build option: define PIO_BIT_CLEAR_EN so edgecapture writes clear only the bits written as 1;
//        otherwise any edgecapture write clears every bit.
import nios_upc_pio_pkg::*;

module nios_upc_pio_edge #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               EDGE_TYPE   = EDGE_RISE,
    parameter int               IRQ_TYPE    = IRQ_LEVEL,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] out_en,
    output logic             irq
);

    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] edge_clr;
    logic             wr;
    logic             unused_wd;

    assign wr        = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    // Bits above WIDTH-1 are deliberately dropped
    assign unused_wd = ^writedata;

    nios_upc_pio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .in_port  (in_port),
        .sync     (sync),
        .edge_det (edge_det)
    );

    always_comb begin
        edge_clr = '0;
        if (wr && address == ADDR_EDGE) begin
`ifdef PIO_BIT_CLEAR_EN
            edge_clr = wd;
`else
            edge_clr = '1;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= RESET_VALUE;
            dir      <= '0;
            mask     <= '0;
            edgecap  <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr) begin
                case (address)
                    ADDR_DATA:   data_out <= wd;
                    ADDR_DIR:    dir      <= wd;
                    ADDR_MASK:   mask     <= wd;
                    ADDR_OUTSET: data_out <= data_out | wd;
                    ADDR_OUTCLR: data_out <= data_out & ~wd;
                    default: ;
                endcase
            end
            // OR-ing the new edge after the clear makes a same-cycle edge survive the clear
            edgecap <= (edgecap & ~edge_clr) | edge_det;
            if (IRQ_TYPE == IRQ_EDGE) irq <= |(edgecap & mask);
            else                      irq <= |(sync & mask);
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: readdata[WIDTH-1:0] = (sync & ~dir) | (data_out & dir);
            ADDR_DIR:  readdata[WIDTH-1:0] = dir;
            ADDR_MASK: readdata[WIDTH-1:0] = mask;
            ADDR_EDGE: readdata[WIDTH-1:0] = edgecap;
            default:   readdata = '0;
        endcase
    end

    assign out_port = data_out;
    assign out_en   = dir;

endmodule

// File: tb/tb_nios_upc_pio_edge.sv
// Directed bench for nios_upc_pio_edge (WIDTH 8, RESET_VALUE A5, rising edges, edge IRQ).
// Latency: n/a.
// Backpressure: n/a.
module tb_nios_upc_pio_edge;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  in_port;
    logic [7:0]  out_port;
    logic [7:0]  out_en;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];

    always #5 clk = ~clk;

    nios_upc_pio_edge #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5),
        .EDGE_TYPE   (0),
        .IRQ_TYPE    (1),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .out_port   (out_port),
        .out_en     (out_en),
        .irq        (irq)
    );

    task automatic push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed %0h", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed %0h expected %0h", t, obs, e);
            end
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        d = readdata;
        chipselect = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        reset      = 1'b1;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        push("rst_out_port", 32'hA5); push("rst_out_en", 32'h00); push("rst_irq", 32'h0);
        push("rst_edgecap", 32'h00);
        #1;
        pop_check({24'h0, out_port});
        pop_check({24'h0, out_en});
        pop_check({31'h0, irq});
        bus_read(3'd3, rd); pop_check(rd);

        // Reset asserted in the middle of a write
        @(negedge clk);
        address = 3'd0; writedata = 32'h11; chipselect = 1'b1; write_n = 1'b0;
        push("midwr_loaded", 32'h11); push("midwr_reset", 32'hA5);
        @(posedge clk); #1;
        pop_check({24'h0, out_port});
        reset = 1'b1;
        #1;
        pop_check({24'h0, out_port});
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; reset = 1'b0;

        // Mixed direction read-back
        bus_write(3'd1, 32'hF0);
        bus_write(3'd0, 32'h3C);
        in_port = 8'h0F;
        repeat (4) @(posedge clk);
        push("mixed_read", 32'h3F); push("dir_read", 32'hF0); push("out_en", 32'hF0);
        bus_read(3'd0, rd); pop_check(rd);
        bus_read(3'd1, rd); pop_check(rd);
        pop_check({24'h0, out_en});

        // Atomic set / clear
        bus_write(3'd0, 32'h0F);
        bus_write(3'd4, 32'hF0);
        bus_write(3'd5, 32'h03);
        push("setclr_out_port", 32'hFC); push("outset_read", 32'h0);
        push("outclr_read", 32'h0); push("reserved_read", 32'h0);
        #1;
        pop_check({24'h0, out_port});
        bus_read(3'd4, rd); pop_check(rd);
        bus_read(3'd5, rd); pop_check(rd);
        bus_read(3'd6, rd); pop_check(rd);

        // Quiet the pins and clear captured edges before edge tests
        in_port = 8'h00;
        repeat (4) @(posedge clk);
        bus_write(3'd3, 32'hFF);
        bus_write(3'd2, 32'h01);
        push("mask_read", 32'h01); push("edge_cleared", 32'h00);
        bus_read(3'd2, rd); pop_check(rd);
        bus_read(3'd3, rd); pop_check(rd);

        // Rising edge on bit0: capture after 3 clocks, irq one later
        @(negedge clk);
        in_port = 8'h01; address = 3'd3;
        push("edge_clk1", 32'h00); push("edge_clk2", 32'h00);
        push("edge_clk3", 32'h01); push("irq_clk3", 32'h0); push("irq_clk4", 32'h1);
        @(posedge clk); #1; pop_check(readdata);
        @(posedge clk); #1; pop_check(readdata);
        @(posedge clk); #1; pop_check(readdata); pop_check({31'h0, irq});
        @(posedge clk); #1; pop_check({31'h0, irq});

        // Clear edgecapture: irq still set right after, drops next cycle
        bus_write(3'd3, 32'h01);
        push("irq_after_clear", 32'h1); push("irq_dropped", 32'h0); push("edge_after_clear", 32'h00);
        pop_check({31'h0, irq});
        @(posedge clk); #1; pop_check({31'h0, irq});
        bus_read(3'd3, rd); pop_check(rd);

        // Edge on bit2 coinciding with a clear write of bit2: set wins
        @(negedge clk);
        in_port = 8'h05;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        address = 3'd3; writedata = 32'h04; chipselect = 1'b1; write_n = 1'b0;
        push("set_wins", 32'h04);
        @(posedge clk); #1;
        pop_check(readdata);
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;

        // Partial clear: edgecap 0x06, write 0x02
        in_port = 8'h07;
        repeat (4) @(posedge clk);
        push("edge_06", 32'h06);
        bus_read(3'd3, rd); pop_check(rd);
        bus_write(3'd3, 32'h02);
`ifdef PIO_BIT_CLEAR_EN
        push("bit_clear", 32'h04);
`else
        push("bit_clear", 32'h00);
`endif
        bus_read(3'd3, rd); pop_check(rd);

        // Final reset drops direction and restores data
        @(negedge clk);
        reset = 1'b1;
        push("final_out_port", 32'hA5); push("final_out_en", 32'h00);
        #1;
        pop_check({24'h0, out_port});
        pop_check({24'h0, out_en});
        @(negedge clk);
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
